// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall controller bundle: decode/execute/memory hazard inputs
// flowing into the controller, and pipeline enable/clear controls plus
// status flowing back out to the datapath.
interface hazard_stall_ctrl_if;
    // D-stage operand usage
    logic [4:0] rs_D;
    logic [4:0] rt_D;
    logic [1:0] tuse_rs_D;
    logic [1:0] tuse_rt_D;
    logic       md_D;

    // E/M-stage producers
    logic [4:0] A3_E;
    logic [1:0] tnew_E;
    logic [4:0] A3_M;
    logic [1:0] tnew_M;

    // MDU start in E
    logic       md_start_E;
    logic       md_is_div_E;

    // Exception / eret flush request
    logic       exc_req;

    // Pipeline controls
    logic        en_F;
    logic        en_D;
    logic        clear_D;
    logic        clear_E;
    logic        clear_M;
    logic        md_busy;
    logic [31:0] stall_cycles;

    // Datapath side: supplies hazard information, consumes controls.
    modport master (
        output rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_D,
        output A3_E, tnew_E, A3_M, tnew_M,
        output md_start_E, md_is_div_E, exc_req,
        input  en_F, en_D, clear_D, clear_E, clear_M, md_busy, stall_cycles
    );

    // Controller side.
    modport slave (
        input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_D,
        input  A3_E, tnew_E, A3_M, tnew_M,
        input  md_start_E, md_is_div_E, exc_req,
        output en_F, en_D, clear_D, clear_E, clear_M, md_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline.
// Detects register RAW hazards that forwarding cannot resolve (Tuse/Tnew),
// stalls MDU-dependent instructions while the multiply/divide unit is
// occupied, applies exception/eret flushes, and counts stall cycles.
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic               clk,
    input logic               reset,
    hazard_stall_ctrl_if.slave bus
);

    // Busy counter wide enough for the longer MDU operation, never below 4 bits.
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_NEED   = $clog2(MAX_CYCLES + 1);
    localparam int CNT_W      = (CNT_NEED < 4) ? 4 : CNT_NEED;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    logic [CNT_W-1:0] md_cnt;
    logic [31:0]      stall_cnt;

    logic stall_rs;
    logic stall_rt;
    logic stall_md;
    logic stall;

    // Hazard detection: a source stalls when its producer's result arrives
    // later than the consumer needs it; $0 and unused operands never stall.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        stall_rs = 1'b0;
        stall_rt = 1'b0;
        stall_md = 1'b0;

        if ((bus.rs_D != 5'd0) && (bus.tuse_rs_D != TUSE_NONE)) begin
            stall_rs = ((bus.rs_D == bus.A3_E) && (bus.tnew_E > bus.tuse_rs_D)) ||
                       ((bus.rs_D == bus.A3_M) && (bus.tnew_M > bus.tuse_rs_D));
        end

        if ((bus.rt_D != 5'd0) && (bus.tuse_rt_D != TUSE_NONE)) begin
            stall_rt = ((bus.rt_D == bus.A3_E) && (bus.tnew_E > bus.tuse_rt_D)) ||
                       ((bus.rt_D == bus.A3_M) && (bus.tnew_M > bus.tuse_rt_D));
        end

        // The start cycle itself blocks via md_start_E; later cycles via md_busy.
        stall_md = bus.md_D && (bus.md_busy || bus.md_start_E);
    end

    assign stall = stall_rs | stall_rt | stall_md;

    // Pipeline controls: an exception flushes D/E/M and lets the handler PC
    // load, overriding any stall; otherwise a stall freezes F/D and bubbles E.
    always_comb begin
        bus.en_F    = 1'b1;
        bus.en_D    = 1'b1;
        bus.clear_D = 1'b0;
        bus.clear_E = 1'b0;
        bus.clear_M = 1'b0;

        if (bus.exc_req) begin
            bus.clear_D = 1'b1;
            bus.clear_E = 1'b1;
            bus.clear_M = 1'b1;
        end else if (stall) begin
            bus.en_F    = 1'b0;
            bus.en_D    = 1'b0;
            bus.clear_E = 1'b1;
        end
    end

    // MDU occupancy: load on an unflushed start (restart allowed), else count down.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every
        // always_ff sees pre-edge values regardless of evaluation order.
        if (reset) begin
            md_cnt <= '0;
        end else if (bus.md_start_E && !bus.exc_req) begin
            md_cnt <= bus.md_is_div_E ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    assign bus.md_busy = (md_cnt != '0);

    // Stall-cycle performance counter; flushed cycles are not counted, wraps at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && !bus.exc_req) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed testbench for hazard_stall_ctrl: load-use, $0 immunity,
// forwarding limits, MDU stall timing, exception flush, reset and wrap.
module tb_hazard_stall_ctrl;

    logic clk;
    logic reset;

    hazard_stall_ctrl_if h ();

    hazard_stall_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (h.slave)
    );

    int vectors;
    int miscompares;

    // Packed control view: {en_F, en_D, clear_D, clear_E, clear_M}
    localparam logic [4:0] CTL_RUN   = 5'b11000;
    localparam logic [4:0] CTL_STALL = 5'b00010;
    localparam logic [4:0] CTL_FLUSH = 5'b11111;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] ctl();
        return {h.en_F, h.en_D, h.clear_D, h.clear_E, h.clear_M};
    endfunction

    task automatic idle();
        h.rs_D        = 5'd0;
        h.rt_D        = 5'd0;
        h.tuse_rs_D   = 2'd3;
        h.tuse_rt_D   = 2'd3;
        h.md_D        = 1'b0;
        h.A3_E        = 5'd0;
        h.tnew_E      = 2'd0;
        h.A3_M        = 5'd0;
        h.tnew_M      = 2'd0;
        h.md_start_E  = 1'b0;
        h.md_is_div_E = 1'b0;
        h.exc_req     = 1'b0;
    endtask

    task automatic load_use();
        idle();
        h.A3_E      = 5'd5;
        h.tnew_E    = 2'd2;
        h.rs_D      = 5'd5;
        h.tuse_rs_D = 2'd1;
    endtask

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run an MDU op followed by an MDU-dependent instruction held in D.
    task automatic mdu_run(input logic is_div, input string tag,
                           input int exp_stalls, input int exp_busy);
        int stalls;
        int busy;
        int release_at;
        stalls     = 0;
        busy       = 0;
        release_at = -1;
        idle();
        h.md_D        = 1'b1;
        h.md_start_E  = 1'b1;
        h.md_is_div_E = is_div;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!h.en_F) stalls++;
            else if (release_at < 0) release_at = i;
            if (h.md_busy) busy++;
            tick();
            h.md_start_E = 1'b0;
        end
        check({tag, "_stalls"}, stalls, exp_stalls);
        check({tag, "_release"}, release_at, exp_stalls);
        check({tag, "_busy"}, busy, exp_busy);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        idle();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        check("rst_busy", h.md_busy, 1'b0);
        check("rst_cnt", h.stall_cycles, 32'd0);

        // Load-use: one bubble, then M-stage forwarding suffices
        load_use();
        #1 check("lu_stall", ctl(), CTL_STALL);
        tick();
        check("lu_cnt1", h.stall_cycles, 32'd1);
        h.A3_E   = 5'd0;
        h.tnew_E = 2'd0;
        h.A3_M   = 5'd5;
        h.tnew_M = 2'd1;
        #1 check("lu_release", ctl(), CTL_RUN);
        tick();
        check("lu_cnt2", h.stall_cycles, 32'd1);

        // $0 never stalls
        idle();
        h.A3_E      = 5'd0;
        h.tnew_E    = 2'd2;
        h.rs_D      = 5'd0;
        h.tuse_rs_D = 2'd0;
        #1 check("zero_run", ctl(), CTL_RUN);
        tick();
        check("zero_cnt", h.stall_cycles, 32'd1);

        // Forwardable vs not: tnew_E=1 against tuse 1 and 0
        idle();
        h.A3_E      = 5'd7;
        h.tnew_E    = 2'd1;
        h.rt_D      = 5'd7;
        h.tuse_rt_D = 2'd1;
        #1 check("fwd_ok", ctl(), CTL_RUN);
        tick();
        h.tuse_rt_D = 2'd0;
        #1 check("fwd_stall", ctl(), CTL_STALL);
        tick();
        check("fwd_cnt", h.stall_cycles, 32'd2);

        // M-stage producer with tnew_M=1 against tuse 0 stalls
        idle();
        h.A3_M      = 5'd9;
        h.tnew_M    = 2'd1;
        h.rs_D      = 5'd9;
        h.tuse_rs_D = 2'd0;
        #1 check("m_stall", ctl(), CTL_STALL);
        tick();
        check("m_cnt", h.stall_cycles, 32'd3);

        // mult then mflo: 6 stalls, busy 5; div: 11 stalls, busy 10
        mdu_run(1'b0, "mult", 6, 5);
        check("mult_cnt", h.stall_cycles, 32'd9);
        mdu_run(1'b1, "div", 11, 10);
        check("div_cnt", h.stall_cycles, 32'd20);

        // Exception overrides a load-use stall and is not counted
        load_use();
        h.exc_req = 1'b1;
        #1 check("exc_flush", ctl(), CTL_FLUSH);
        tick();
        check("exc_cnt", h.stall_cycles, 32'd20);

        // MDU start with exception is ignored
        idle();
        h.md_start_E  = 1'b1;
        h.md_is_div_E = 1'b1;
        h.exc_req     = 1'b1;
        #1 check("exc_md_flush", ctl(), CTL_FLUSH);
        tick();
        check("exc_md_busy", h.md_busy, 1'b0);

        // Reset mid-div: counter at 6 after start + 4 edges
        idle();
        h.md_start_E  = 1'b1;
        h.md_is_div_E = 1'b1;
        tick();
        h.md_start_E = 1'b0;
        repeat (4) tick();
        check("div_busy_pre", h.md_busy, 1'b1);
        load_use();
        h.md_start_E  = 1'b1;
        h.md_is_div_E = 1'b1;
        reset = 1'b1;
        #1 check("rst_comb", ctl(), CTL_STALL);
        tick();
        reset = 1'b0;
        idle();
        check("rst_mid_busy", h.md_busy, 1'b0);
        check("rst_mid_cnt", h.stall_cycles, 32'd0);
        tick();
        check("rst_after_busy", h.md_busy, 1'b0);

        // Wrap: preload counter to all-ones with no stall, then stall once
        force dut.stall_cnt = 32'hFFFF_FFFF;
        tick();
        release dut.stall_cnt;
        #1 check("wrap_pre", h.stall_cycles, 32'hFFFF_FFFF);
        load_use();
        tick();
        check("wrap_zero", h.stall_cycles, 32'd0);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Control block that drives the stage-enable and flush inputs of the F/D/E/M pipeline registers in the 5-stage MIPS core. It produces En for F/D, clear for the D→E register, and clear for the D and M registers.
- Detects RAW hazards that forwarding cannot cover, using the Tuse/Tnew method.
- Models multiply/divide unit occupancy with an internal busy counter.
- Applies exception/eret flushes. Also keeps a stall-cycle performance counter.

Parameters:
- MULT_CYCLES, 5, cycles the MDU is busy after a mult/multu start
- DIV_CYCLES, 10, cycles the MDU is busy after a div/divu start

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- rs_D  input  5  rs field of the instruction in D
- rt_D  input  5  rt field of the instruction in D
- tuse_rs_D  input  2  cycles until D needs rs (0..2; 3 = not used)
- tuse_rt_D  input  2  cycles until D needs rt (0..2; 3 = not used)
- md_D  input  1  D instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- A3_E  input  5  destination register of the E instruction (0 = none)
- tnew_E  input  2  cycles until the E result is available (0..2)
- A3_M  input  5  destination register of the M instruction
- tnew_M  input  2  cycles until the M result is available (0..1)
- md_start_E  input  1  E instruction starts the MDU this cycle
- md_is_div_E  input  1  qualifies md_start_E: 1 = div/divu, 0 = mult/multu
- exc_req  input  1  exception or eret taken this cycle; flush
- en_F  output  1  PC/F-register enable
- en_D  output  1  F→D register enable
- clear_D  output  1  F→D register clear
- clear_E  output  1  D→E register clear (inserts a bubble)
- clear_M  output  1  E→M register clear
- md_busy  output  1  MDU busy counter nonzero
- stall_cycles  output  32  count of stall cycles since reset

Behaviour:
- Register hazard:
  - stall_rs = (rs_D!=0) & (tuse_rs_D!=3) & [ ((rs_D==A3_E) & (tnew_E>tuse_rs_D)) | ((rs_D==A3_M) & (tnew_M>tuse_rs_D)) ]
  - stall_rt is the same expression with rt_D and tuse_rt_D.
  - $0 never stalls.
- MD hazard: stall_md = md_D & (md_busy | md_start_E).
- Combined: stall = stall_rs | stall_rt | stall_md. All outputs except md_busy and stall_cycles are combinational, with zero latency.
- When exc_req=0:
  - en_F = en_D = ~stall
  - clear_E = stall
  - clear_D = clear_M = 0
- When exc_req=1 (highest priority, overrides stall):
  - en_F = en_D = 1, so the handler PC loads.
  - clear_D = clear_E = clear_M = 1.
- MDU busy counter (4-bit min, sized to max(MULT_CYCLES, DIV_CYCLES)):
  - On the clock edge with md_start_E=1 and exc_req=0, load DIV_CYCLES if md_is_div_E=1, else MULT_CYCLES.
  - Otherwise, if nonzero, decrement by 1.
  - md_busy = (count!=0), a registered view.
  - md_start_E while busy reloads the counter; a restart is legal.
  - md_start_E with exc_req=1 is ignored; the counter continues decrementing.
- stall_cycles:
  - Increments by 1 on every edge where stall=1 and exc_req=0.
  - Wraps from 0xFFFFFFFF to 0.
- Reset:
  - On the edge with reset=1, the counter is set to 0, md_busy=0 and stall_cycles=0. Reset overrides md_start_E.
  - While reset is high, combinational outputs follow their equations. Pipeline registers also reset themselves, so this is harmless.
  - Reset asserted mid-MDU operation abandons it: md_busy=0 on the next cycle.
- Ordering: a mult started in E makes an mflo in D stall for exactly MULT_CYCLES+1 cycles.
  - The start cycle counts as 1 cycle, via md_start_E.
  - The following MULT_CYCLES cycles count via md_busy.
  - The mflo is released in the cycle after the counter reaches 0.

Test Plan:
- Load-use: lw $5 with A3_E=5, tnew_E=2; D instruction has rs_D=5, tuse_rs_D=1 → 1 cycle with en_F=en_D=0 and clear_E=1. Next cycle A3_M=5, tnew_M=1 → no stall. stall_cycles=1.
- $0 immunity: A3_E=0, tnew_E=2, rs_D=0, tuse_rs_D=0 → en_F=1, clear_E=0, stall_cycles unchanged.
- Forwardable case: A3_E=7, tnew_E=1, rt_D=7, tuse_rt_D=1 → no stall. Same with tuse_rt_D=0 → stall for 1 cycle.
- mult then mflo: pulse md_start_E=1 with md_is_div_E=0, md_D held 1 → stall exactly 6 consecutive cycles; md_busy high for 5 cycles. Repeat with div → 11 cycles stalled, busy for 10.
- Exception during stall: load-use stall active and exc_req=1 → en_F=en_D=1, clear_D=clear_E=clear_M=1, stall_cycles not incremented. md_start_E with exc_req=1 → md_busy stays 0.
- Reset mid-div: div started, counter=6; reset=1 for one cycle → md_busy=0 and stall_cycles=0 the following cycle. Next, force stall_cycles to 0xFFFFFFFF, then stall 1 cycle → stall_cycles wraps to 0.
